// File: rtl/channel_accumulator.sv
// Purpose : steps the channel selector through channels 0..IN_CH-1 and sums the selected words per lane.
// Latency : o_valid rises IN_CH cycles after the accept edge; accept-to-accept is IN_CH+2 cycles minimum.
// Backpressure: o_valid/o_data hold in DONE until i_ready; o_in_ready is high only in IDLE.
//
// Ports:
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   i_valid        : upstream has a stable multi-channel set (held until o_valid rises)
//   o_in_ready     : set accepted on an edge where i_valid and o_in_ready are both high
//   o_ch_sel       : registered channel index driven to the selector
//   i_sel_data     : selector output, lane k = [k*WIDTH +: WIDTH], signed
//   o_valid/i_ready: result handshake towards the next stage
//   o_data         : per-lane sums, lane k = [k*ACC_WIDTH +: ACC_WIDTH]
//
// ACC_WIDTH must be >= WIDTH + $clog2(IN_CH) so the sums never wrap.

module channel_accumulator #(
    parameter int WIDTH     = 30,
    parameter int IN_CH     = 3,
    parameter int OUT_NUM   = 2,
    parameter int ACC_WIDTH = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    output logic                           o_in_ready,
    output logic [$clog2(IN_CH):0]         o_ch_sel,
    input  logic [WIDTH*OUT_NUM-1:0]       i_sel_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [ACC_WIDTH*OUT_NUM-1:0]   o_data
);

    localparam int CW = $clog2(IN_CH) + 1;
    localparam logic [CW-1:0] LAST_CH = CW'(IN_CH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]                     state;
    logic [CW-1:0]                  ch_cnt;
    logic [ACC_WIDTH*OUT_NUM-1:0]   acc_sum;

    // o_data doubles as the accumulator; each lane adds the sign-extended
    // selector word for the channel currently on o_ch_sel.
    always_comb begin
        acc_sum = o_data;
        for (int k = 0; k < OUT_NUM; k++) begin
            acc_sum[k*ACC_WIDTH +: ACC_WIDTH] =
                o_data[k*ACC_WIDTH +: ACC_WIDTH]
                + ACC_WIDTH'($signed(i_sel_data[k*WIDTH +: WIDTH]));
        end
    end

    assign o_in_ready = (state == IDLE);
    assign o_ch_sel   = ch_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            ch_cnt  <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        state  <= ACCUM;
                        ch_cnt <= '0;
                        o_data <= '0;
                    end
                end
                ACCUM: begin
                    o_data <= acc_sum;
                    if (ch_cnt == LAST_CH) begin
                        ch_cnt  <= '0;
                        state   <= DONE;
                        o_valid <= 1'b1;
                    end else begin
                        ch_cnt <= ch_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ch_cnt  <= '0;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_channel_accumulator.sv
module tb_channel_accumulator;

    localparam int WIDTH     = 30;
    localparam int IN_CH     = 3;
    localparam int OUT_NUM   = 2;
    localparam int ACC_WIDTH = 32;
    localparam int CW        = $clog2(IN_CH) + 1;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b1;
    logic                          valid_in = 1'b0;
    logic                          in_ready;
    logic [CW-1:0]                 ch_sel;
    logic [WIDTH*OUT_NUM-1:0]      sel_data;
    logic                          out_valid;
    logic                          ready_in = 1'b0;
    logic [ACC_WIDTH*OUT_NUM-1:0]  data_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_accept = 0;

    // channel contents presented by the modelled selector
    logic signed [WIDTH-1:0] chan [IN_CH][OUT_NUM];

    channel_accumulator #(
        .WIDTH(WIDTH), .IN_CH(IN_CH), .OUT_NUM(OUT_NUM), .ACC_WIDTH(ACC_WIDTH)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_valid(valid_in),
        .o_in_ready(in_ready),
        .o_ch_sel(ch_sel),
        .i_sel_data(sel_data),
        .o_valid(out_valid),
        .i_ready(ready_in),
        .o_data(data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // selector model: lane k of the currently selected channel
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < OUT_NUM; k++) begin
            if (int'(ch_sel) < IN_CH)
                sel_data[k*WIDTH +: WIDTH] = chan[int'(ch_sel)][k];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_random();
        for (int c = 0; c < IN_CH; c++)
            for (int k = 0; k < OUT_NUM; k++)
                chan[c][k] = WIDTH'($urandom);
    endtask

    task automatic load_const(input logic signed [WIDTH-1:0] v);
        for (int c = 0; c < IN_CH; c++)
            for (int k = 0; k < OUT_NUM; k++)
                chan[c][k] = v;
    endtask

    task automatic load_basic();
        chan[0][0] = WIDTH'(5);  chan[0][1] = WIDTH'(-2);
        chan[1][0] = WIDTH'(7);  chan[1][1] = WIDTH'(3);
        chan[2][0] = WIDTH'(-1); chan[2][1] = WIDTH'(4);
    endtask

    // One complete set, starting and ending at a negedge with the DUT idle.
    task automatic run_set(input int stall, input bit noise, input bit keep_valid, input bit b2b);
        logic [ACC_WIDTH-1:0]         exp_lane [OUT_NUM];
        logic [ACC_WIDTH*OUT_NUM-1:0] held;
        for (int k = 0; k < OUT_NUM; k++) begin
            longint s = 0;
            for (int c = 0; c < IN_CH; c++) s += longint'(chan[c][k]);
            exp_lane[k] = ACC_WIDTH'(s);
        end

        check("in_ready_idle", 64'(in_ready), 64'd1);
        valid_in = 1'b1;
        if (b2b) check("b2b_gap", 64'(cyc + 1 - last_accept), 64'(IN_CH + 2));
        last_accept = cyc + 1;
        @(negedge clk);
        valid_in = keep_valid;
        check("acc_clear", 64'(data_out), 64'd0);
        for (int c = 0; c < IN_CH; c++) begin
            if (c > 0) @(negedge clk);
            check("ch_sel", 64'(ch_sel), 64'(c));
            check("valid_low", 64'(out_valid), 64'd0);
            check("in_ready_busy", 64'(in_ready), 64'd0);
            if (noise) valid_in = 1'($urandom_range(0, 1));
            ready_in = (c == IN_CH - 1) ? (stall == 0) : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("valid_rise", 64'(out_valid), 64'd1);
        for (int k = 0; k < OUT_NUM; k++)
            check("lane_sum", 64'(data_out[k*ACC_WIDTH +: ACC_WIDTH]), 64'(exp_lane[k]));
        held = data_out;
        for (int s = 0; s < stall; s++) begin
            if (noise) valid_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(data_out), 64'(held));
            check("in_ready_done", 64'(in_ready), 64'd0);
        end
        valid_in = keep_valid;
        ready_in = 1'b1;
        @(negedge clk);
        check("valid_drop", 64'(out_valid), 64'd0);
        check("in_ready_back", 64'(in_ready), 64'd1);
        check("data_kept", 64'(data_out), 64'(held));
        ready_in = 1'($urandom_range(0, 1));
    endtask

    initial begin
        load_basic();
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(data_out), 64'd0);
        check("rst_ch_sel", 64'(ch_sel), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // basic set with fixed data, plus explicit known totals
        run_set(0, 1'b0, 1'b0, 1'b0);
        run_set(5, 1'b0, 1'b0, 1'b0);
        // after the stalled run o_data keeps the last result in IDLE
        check("basic_lane0", 64'(data_out[0 +: ACC_WIDTH]), 64'd11);
        check("basic_lane1", 64'(data_out[ACC_WIDTH +: ACC_WIDTH]), 64'd5);

        // extremes
        load_const(WIDTH'(-(64'sd1 <<< 29)));
        run_set(1, 1'b0, 1'b0, 1'b0);
        load_const(WIDTH'((64'sd1 <<< 29) - 1));
        run_set(0, 1'b0, 1'b0, 1'b0);

        // back-to-back with i_valid held high
        load_random();
        run_set(0, 1'b0, 1'b1, 1'b0);
        load_random();
        run_set(0, 1'b0, 1'b1, 1'b1);
        load_random();
        run_set(0, 1'b0, 1'b0, 1'b1);

        // i_valid noise during ACCUM/DONE, random backpressure
        for (int i = 0; i < 8; i++) begin
            load_random();
            run_set($urandom_range(0, 4), 1'b1, 1'b0, 1'b0);
        end

        // reset mid-ACCUM at counter 1
        load_basic();
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        check("pre_rst_ch_sel", 64'(ch_sel), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ch_sel", 64'(ch_sel), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", 64'(data_out), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < IN_CH + 2; i++) begin
            @(negedge clk);
            check("post_rst_idle", 64'(in_ready), 64'd1);
            check("post_rst_no_valid", 64'(out_valid), 64'd0);
        end
        load_random();
        run_set(2, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/channel_accumulator.md
Name: channel_accumulator

Overview:
- Sequencer and accumulator placed directly downstream of the channel selector.
- Steps the selector's channel-select input through channels 0..IN_CH-1, one channel per cycle.
- Sums the OUT_NUM selected words per lane across all input channels and presents the per-lane totals with a valid/ready handshake to the next stage.
- Upstream holds the selector's flat input bus stable from acceptance (i_valid and o_in_ready both high) until o_valid rises.

Parameters:
- WIDTH, 30: bits per selected word (signed two's complement).
- IN_CH, 3: number of input channels to accumulate.
- OUT_NUM, 2: parallel lanes per channel.
- ACC_WIDTH, 32: bits per accumulator lane. Must be >= WIDTH+$clog2(IN_CH).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream has a complete stable multi-channel set.
- o_in_ready  out  1  block accepts a new set (high only in IDLE).
- o_ch_sel  out  $clog2(IN_CH)+1  channel index driven to the selector.
- i_sel_data  in  WIDTH*OUT_NUM  selector output. Lane k is bits [k*WIDTH +: WIDTH].
- o_valid  out  1  accumulated result available.
- i_ready  in  1  downstream accepts the result.
- o_data  out  ACC_WIDTH*OUT_NUM  per-lane sums. Lane k is bits [k*ACC_WIDTH +: ACC_WIDTH].

Behaviour:
- One clock (i_clk). Reset is asynchronous and active-low (i_rst_n).
- Reset values: state=IDLE, channel counter=0, o_ch_sel=0, o_valid=0, o_data=0, o_in_ready=1 (combinational from state).
- o_ch_sel is the registered channel counter, driven directly with no combinational path from inputs.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - o_in_ready=1.
  - On a clock edge with i_valid=1: state<=ACCUM, counter<=0, all accumulator lanes<=0.
  - Otherwise hold. o_data keeps its last result.
- ACCUM:
  - o_in_ready=0. i_valid is ignored.
  - Each edge: acc[k] <= acc[k] + sign_extend(i_sel_data lane k) to ACC_WIDTH, for every k. Counter increments.
  - On the edge where counter==IN_CH-1: counter<=0, state<=DONE, o_valid<=1. o_data carries the final sums from that edge.
- DONE:
  - o_valid=1. o_data is stable while o_valid=1.
  - i_ready=1 at an edge: o_valid<=0, state<=IDLE.
  - i_ready=0: hold indefinitely.
  - i_valid is ignored in DONE. No overlap with a new accept; a new accept is possible at the earliest one cycle after the handshake.
- Latency: o_valid rises exactly IN_CH cycles after the accept edge. The accept-to-accept minimum is IN_CH+2 cycles with i_ready tied high.
- The accumulator register is o_data. It is cleared at accept, so o_data reads 0 during the first ACCUM cycle.
- Arithmetic: signed addition with no saturation. No overflow is possible given the ACC_WIDTH constraint.
- IN_CH=1: ACCUM lasts a single cycle.
- Reset asserted in any state: immediate return to reset values. The partial result is discarded and no o_valid is produced.
- i_ready asserted while not in DONE: no effect.

Test Plan:
- Reset: hold i_rst_n=0 mid-ACCUM at counter=1 → all outputs return to reset values asynchronously. After release, state is IDLE and o_in_ready=1.
- Basic accumulation (IN_CH=3, OUT_NUM=2): model the selector with ch0=(5,-2), ch1=(7,3), ch2=(-1,4); pulse i_valid, i_ready=1 → o_ch_sel sequence 0,1,2. o_valid rises 3 cycles after accept with lane0=11, lane1=5. o_valid drops the next cycle.
- Backpressure: same data, i_ready=0 for 5 cycles after o_valid → o_valid and o_data (11,5) held constant. o_in_ready=0 and i_valid is ignored throughout. Raise i_ready → IDLE on the next edge.
- Extremes: every channel and lane = -2^29 → each lane = -3·2^29 (sign-extended, exact). Every channel and lane = 2^29-1 → each lane = 3·(2^29-1).
- Back-to-back: i_valid held high continuously, i_ready=1 → accepts occur every 5 cycles. The second set's result is independent of the first (accumulator cleared to 0 at each accept).
- i_valid pulsed during ACCUM and DONE → no restart and no counter disturbance. The result equals the single-set result.
